// File: rtl/prog_mem_loader.sv
// prog_mem_loader
//   Writable 16x8 program store feeding the 4-bit CPU core. In RUN the CPU
//   reads instructions combinationally by address. A load-mode FSM accepts one
//   byte per synchronised rising edge of wr_strobe while load_req is held. The
//   CPU is kept in reset for the whole load and for one release cycle after it.
//
//   Optional feature macro: PROG_CHECKSUM_EN adds the checksum[7:0] output,
//   which is the XOR of every byte accepted since the last load entry.
//
// Ports
//   clk          system clock
//   n_reset      asynchronous active-low reset
//   load_req     async level, 1 = enter/stay in load mode
//   wr_strobe    async, each synchronised rising edge writes one byte
//   wr_data      byte to write, stable around the strobe edge
//   cpu_addr     CPU program counter
//   instr        instruction to the CPU (8'h00 while not in RUN)
//   cpu_n_reset  active-low reset to the CPU
//   load_active  1 in LOAD, DONE and RELEASE
//   load_addr    next word to be written
//   load_done    1 once all 16 words are written, until release
//   checksum     (PROG_CHECKSUM_EN only) XOR of accepted bytes
module prog_mem_loader #(
    parameter int           DEPTH       = 16,
    parameter int           WIDTH       = 8,
    parameter int           SYNC_STAGES = 2,
    parameter logic [7:0]   FILL        = 8'h00
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             load_req,
    input  logic             wr_strobe,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       cpu_addr,
    output logic [WIDTH-1:0] instr,
    output logic             cpu_n_reset,
    output logic             load_active,
    output logic [3:0]       load_addr,
    output logic             load_done
`ifdef PROG_CHECKSUM_EN
    ,
    output logic [7:0]       checksum
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic [SYNC_STAGES-1:0] strb_sync_q, strb_sync_d;
    logic                   strb_prev_q, strb_prev_d;
    logic [3:0]             load_addr_q, load_addr_d;
    logic                   cpu_run_q, cpu_run_d;
    logic                   load_active_q, load_active_d;
    logic                   load_done_q, load_done_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
`ifdef PROG_CHECKSUM_EN
    logic [7:0]             chk_q, chk_d;
`endif

    logic req_s;
    logic strb_edge;

    assign req_s     = req_sync_q[SYNC_STAGES-1];
    // Edge detection runs in every state, so a strobe already high when LOAD
    // is entered produces no edge until it falls and rises again.
    assign strb_edge = strb_sync_q[SYNC_STAGES-1] & ~strb_prev_q;

    always_comb begin
        req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], load_req};
        strb_sync_d = {strb_sync_q[SYNC_STAGES-2:0], wr_strobe};
        strb_prev_d = strb_sync_q[SYNC_STAGES-1];
        state_d     = state_q;
        load_addr_d = load_addr_q;
        mem_d       = mem_q;
`ifdef PROG_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        case (state_q)
            RUN: begin
                if (req_s) begin
                    state_d     = LOAD;
                    load_addr_d = '0;
`ifdef PROG_CHECKSUM_EN
                    chk_d       = '0;
`endif
                end
            end
            LOAD: begin
                // Release takes priority over a coincident strobe edge.
                if (!req_s) begin
                    state_d = RELEASE;
                end else if (strb_edge) begin
                    mem_d[load_addr_q] = wr_data;
                    load_addr_d        = load_addr_q + 1'b1;
`ifdef PROG_CHECKSUM_EN
                    chk_d              = chk_q ^ wr_data;
`endif
                    if (load_addr_q == 4'(DEPTH - 1))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (!req_s)
                    state_d = RELEASE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Status outputs are registered from the next state so they line up
        // with state_q on the following cycle.
        cpu_run_d     = (state_d == RUN);
        load_active_d = (state_d != RUN);
        load_done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= RUN;
            req_sync_q    <= '0;
            strb_sync_q   <= '0;
            strb_prev_q   <= 1'b0;
            load_addr_q   <= '0;
            cpu_run_q     <= 1'b1;
            load_active_q <= 1'b0;
            load_done_q   <= 1'b0;
            mem_q         <= '{default: FILL};
`ifdef PROG_CHECKSUM_EN
            chk_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_sync_q    <= req_sync_d;
            strb_sync_q   <= strb_sync_d;
            strb_prev_q   <= strb_prev_d;
            load_addr_q   <= load_addr_d;
            cpu_run_q     <= cpu_run_d;
            load_active_q <= load_active_d;
            load_done_q   <= load_done_d;
            mem_q         <= mem_d;
`ifdef PROG_CHECKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

    always_comb begin
        instr = '0;
        if (state_q == RUN)
            instr = mem_q[cpu_addr];
    end

    assign cpu_n_reset = n_reset & cpu_run_q;
    assign load_active = load_active_q;
    assign load_addr   = load_addr_q;
    assign load_done   = load_done_q;
`ifdef PROG_CHECKSUM_EN
    assign checksum    = chk_q;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       load_req = 1'b0;
    logic       wr_strobe = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [3:0] cpu_addr = 4'h0;
    logic [7:0] instr;
    logic       cpu_n_reset;
    logic       load_active;
    logic [3:0] load_addr;
    logic       load_done;
`ifdef PROG_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_mem [16];
    logic [7:0] prog [16] = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                              8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};

    prog_mem_loader #(.DEPTH(16), .WIDTH(8), .SYNC_STAGES(2), .FILL(8'h00)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .load_req    (load_req),
        .wr_strobe   (wr_strobe),
        .wr_data     (wr_data),
        .cpu_addr    (cpu_addr),
        .instr       (instr),
        .cpu_n_reset (cpu_n_reset),
        .load_active (load_active),
        .load_addr   (load_addr),
        .load_done   (load_done)
`ifdef PROG_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers (no checking inside).
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sync (2) + edge (1) = write on 3rd edge; 3 low cycles clear the edge detector.
    task automatic pulse_strobe(input logic [7:0] d);
        wr_data   = d;
        wr_strobe = 1'b1;
        tick(3);
        wr_strobe = 1'b0;
        tick(3);
    endtask

    task automatic enter_load;
        load_req = 1'b1;
        tick(3);
    endtask

    task automatic leave_load;
        load_req = 1'b0;
        tick(4);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (cpu_n_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_cpu_n_reset_low got=%b exp=0", cpu_n_reset);
        end
        checks++;
        if (load_active !== 1'b0 || load_done !== 1'b0 || load_addr !== 4'h0) begin
            failures++;
            $display("FAIL reset_status got act=%b done=%b addr=%h exp 0/0/0",
                     load_active, load_done, load_addr);
        end
        tick(2);
        n_reset = 1'b1;
        tick(1);
        checks++;
        if (cpu_n_reset !== 1'b1) begin
            failures++;
            $display("FAIL reset_cpu_n_reset_high got=%b exp=1", cpu_n_reset);
        end
        for (int a = 0; a < 16; a++) begin
            exp_mem[a] = 8'h00;
            cpu_addr = 4'(a);
            #1;
            checks++;
            if (instr !== 8'h00) begin
                failures++;
                $display("FAIL reset_word[%0d] got=%h exp=00", a, instr);
            end
        end
    endtask

    task automatic test_full_load;
        enter_load();
        cpu_addr = 4'h0;
        #1;
        checks++;
        if (load_active !== 1'b1 || cpu_n_reset !== 1'b0 || instr !== 8'h00 || load_addr !== 4'h0) begin
            failures++;
            $display("FAIL full_entry got act=%b cpun=%b instr=%h addr=%h exp 1/0/00/0",
                     load_active, cpu_n_reset, instr, load_addr);
        end
        for (int i = 0; i < 16; i++) begin
            pulse_strobe(prog[i]);
            checks++;
            if (load_addr !== 4'((i + 1) % 16)) begin
                failures++;
                $display("FAIL full_addr[%0d] got=%h exp=%h", i, load_addr, 4'((i + 1) % 16));
            end
        end
        checks++;
        if (load_done !== 1'b1 || load_active !== 1'b1 || cpu_n_reset !== 1'b0) begin
            failures++;
            $display("FAIL full_done got done=%b act=%b cpun=%b exp 1/1/0",
                     load_done, load_active, cpu_n_reset);
        end
        // 17th strobe in DONE must be ignored.
        pulse_strobe(8'h55);
        checks++;
        if (load_addr !== 4'h0 || load_done !== 1'b1) begin
            failures++;
            $display("FAIL done_extra_strobe got addr=%h done=%b exp 0/1", load_addr, load_done);
        end
        load_req = 1'b0;
        tick(3);
        checks++;
        if (cpu_n_reset !== 1'b0 || load_done !== 1'b0 || load_active !== 1'b1) begin
            failures++;
            $display("FAIL release_cycle got cpun=%b done=%b act=%b exp 0/0/1",
                     cpu_n_reset, load_done, load_active);
        end
        tick(1);
        checks++;
        if (cpu_n_reset !== 1'b1 || load_active !== 1'b0) begin
            failures++;
            $display("FAIL run_after_release got cpun=%b act=%b exp 1/0", cpu_n_reset, load_active);
        end
        cpu_addr = 4'h0;
        #1;
        checks++;
        if (instr !== 8'hB7) begin
            failures++;
            $display("FAIL full_word0 got=%h exp=b7", instr);
        end
        cpu_addr = 4'hF;
        #1;
        checks++;
        if (instr !== 8'hFF) begin
            failures++;
            $display("FAIL full_word15 got=%h exp=ff", instr);
        end
        for (int a = 0; a < 16; a++) begin
            exp_mem[a] = prog[a];
            cpu_addr = 4'(a);
            #1;
            checks++;
            if (instr !== exp_mem[a]) begin
                failures++;
                $display("FAIL full_word[%0d] got=%h exp=%h", a, instr, exp_mem[a]);
            end
        end
    endtask

    task automatic test_partial_load;
        enter_load();
        pulse_strobe(8'hAA);
        pulse_strobe(8'hBB);
        pulse_strobe(8'hCC);
        checks++;
        if (load_addr !== 4'h3) begin
            failures++;
            $display("FAIL partial_addr got=%h exp=3", load_addr);
        end
        leave_load();
        exp_mem[0] = 8'hAA;
        exp_mem[1] = 8'hBB;
        exp_mem[2] = 8'hCC;
        for (int a = 0; a < 16; a++) begin
            cpu_addr = 4'(a);
            #1;
            checks++;
            if (instr !== exp_mem[a]) begin
                failures++;
                $display("FAIL partial_word[%0d] got=%h exp=%h", a, instr, exp_mem[a]);
            end
        end
    endtask

    task automatic test_strobe_held;
        wr_data   = 8'h77;
        wr_strobe = 1'b1;
        tick(4);
        enter_load();
        tick(4);
        checks++;
        if (load_active !== 1'b1 || load_addr !== 4'h0) begin
            failures++;
            $display("FAIL held_entry got act=%b addr=%h exp 1/0", load_active, load_addr);
        end
        wr_strobe = 1'b0;
        tick(3);
        checks++;
        if (load_addr !== 4'h0) begin
            failures++;
            $display("FAIL held_fall got addr=%h exp=0", load_addr);
        end
        leave_load();
        cpu_addr = 4'h0;
        #1;
        checks++;
        if (instr !== exp_mem[0]) begin
            failures++;
            $display("FAIL held_word0 got=%h exp=%h", instr, exp_mem[0]);
        end
    endtask

    task automatic test_release_priority;
        enter_load();
        pulse_strobe(8'h5A);
        exp_mem[0] = 8'h5A;
        // Strobe rise and load_req drop reach the FSM in the same cycle.
        wr_data   = 8'hC3;
        wr_strobe = 1'b1;
        load_req  = 1'b0;
        tick(4);
        wr_strobe = 1'b0;
        tick(3);
        checks++;
        if (load_addr !== 4'h1 || load_active !== 1'b0) begin
            failures++;
            $display("FAIL prio_state got addr=%h act=%b exp 1/0", load_addr, load_active);
        end
        for (int a = 0; a < 2; a++) begin
            cpu_addr = 4'(a);
            #1;
            checks++;
            if (instr !== exp_mem[a]) begin
                failures++;
                $display("FAIL prio_word[%0d] got=%h exp=%h", a, instr, exp_mem[a]);
            end
        end
    endtask

    task automatic test_async_reset;
        enter_load();
        pulse_strobe(8'h11);
        pulse_strobe(8'h22);
        pulse_strobe(8'h33);
        pulse_strobe(8'h44);
        pulse_strobe(8'h55);
        checks++;
        if (load_addr !== 4'h5) begin
            failures++;
            $display("FAIL areset_pre_addr got=%h exp=5", load_addr);
        end
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if (load_addr !== 4'h0 || load_active !== 1'b0 || cpu_n_reset !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL areset_async got addr=%h act=%b cpun=%b done=%b exp 0/0/0/0",
                     load_addr, load_active, cpu_n_reset, load_done);
        end
        load_req = 1'b0;
        tick(1);
        n_reset = 1'b1;
        tick(2);
        checks++;
        if (cpu_n_reset !== 1'b1 || load_active !== 1'b0) begin
            failures++;
            $display("FAIL areset_run got cpun=%b act=%b exp 1/0", cpu_n_reset, load_active);
        end
        for (int a = 0; a < 16; a++) begin
            exp_mem[a] = 8'h00;
            cpu_addr = 4'(a);
            #1;
            checks++;
            if (instr !== 8'h00) begin
                failures++;
                $display("FAIL areset_word[%0d] got=%h exp=00", a, instr);
            end
        end
    endtask

`ifdef PROG_CHECKSUM_EN
    task automatic test_checksum;
        enter_load();
        checks++;
        if (checksum !== 8'h00) begin
            failures++;
            $display("FAIL chk_entry got=%h exp=00", checksum);
        end
        pulse_strobe(8'h01);
        pulse_strobe(8'h02);
        pulse_strobe(8'h04);
        pulse_strobe(8'h08);
        checks++;
        if (checksum !== 8'h0F) begin
            failures++;
            $display("FAIL chk_value got=%h exp=0f", checksum);
        end
        leave_load();
        checks++;
        if (checksum !== 8'h0F) begin
            failures++;
            $display("FAIL chk_held got=%h exp=0f", checksum);
        end
        enter_load();
        checks++;
        if (checksum !== 8'h00) begin
            failures++;
            $display("FAIL chk_clear got=%h exp=00", checksum);
        end
        leave_load();
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_partial_load();
        test_strobe_held();
        test_release_priority();
        test_async_reset();
`ifdef PROG_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
